// File: rtl/mpu6050_sampler.sv
// mpu6050_sampler
//   I2C master for an MPU6050 accelerometer. After reset it wakes the device
//   once by writing PWR_MGMT_1 (0x6B) = 0x00. It then burst-reads
//   ACCEL_XOUT_H..ACCEL_ZOUT_L (0x3B..0x40) on every enabled sample tick and
//   presents the three signed axes with a one-cycle data_valid strobe.
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   enable       gates sample ticks; the wake write runs regardless
//   sda_i        SDA pad input (the only bus input; no clock stretching)
//   scl_oe       1 = pull SCL low, 0 = release
//   sda_oe       1 = pull SDA low, 0 = release
//   data_valid   one-cycle strobe, ax/ay/az carry a new sample
//   ax, ay, az   signed 16-bit big-endian register pairs
//   init_done    sticky, set after a fully ACKed wake write
//   busy         high from START through the last STOP quarter
//   ack_error    one-cycle pulse on a NACK of an address or write byte
//   overrun      one-cycle pulse when an enabled tick lands while busy
//
// Output protocol: data_valid is a push-only strobe with no ready. The
// consumer must capture ax/ay/az in the cycle data_valid is high; the values
// then hold until the next successful read.
//
// Bus timing: every bit is four quarters of QTR clocks. scl_oe/sda_oe are
// registered from the current quarter position, so the pads follow the
// sequencer by one clock; this lag is uniform and keeps all edges ordered.
module mpu6050_sampler #(
  parameter int         CLK_FREQ_HZ    = 50_000_000,
  parameter int         I2C_FREQ_HZ    = 400_000,
  parameter int         SAMPLE_RATE_HZ = 50,
  parameter logic [6:0] DEV_ADDR       = 7'h68
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               sda_i,
  output logic               scl_oe,
  output logic               sda_oe,
  output logic               data_valid,
  output logic signed [15:0] ax,
  output logic signed [15:0] ay,
  output logic signed [15:0] az,
  output logic               init_done,
  output logic               busy,
  output logic               ack_error,
  output logic               overrun
);

  localparam int QTR_RAW    = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
  localparam int QTR        = (QTR_RAW < 1) ? 1 : QTR_RAW;
  localparam int DIV_RAW    = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
  localparam int SAMPLE_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int QW         = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int TW         = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [7:0] ADDR_WR = {DEV_ADDR, 1'b0};
  localparam logic [7:0] ADDR_RD = {DEV_ADDR, 1'b1};

  typedef enum logic [3:0] {
    INIT_WR, IDLE, RD_ADDR, RD_PTR, RSTART, RD_DEV, RD_BYTES, STOP, DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE, OP_START, OP_SR, OP_STOP, OP_WR, OP_RD
  } op_t;

  state_t        state;
  logic [1:0]    step;       // sub-step inside INIT_WR / RD_ADDR
  logic [QW-1:0] qcnt;       // clock within the current quarter
  logic [1:0]    qtr;        // quarter within the current bit
  logic [3:0]    bitn;       // 0..7 data bits, 8 = ACK bit
  logic [2:0]    byte_idx;   // read byte 0..5
  logic [7:0]    shreg;
  logic [47:0]   rd_buf;
  logic          nack_seen;  // ACK bit of the last write byte was high
  logic          nack_flag;  // current STOP closes a failed transaction
  logic          from_init;  // current STOP closes the wake write
  logic          init_req;   // wake write pending right after reset
  logic [TW-1:0] tick_cnt;

  op_t        op;
  logic [7:0] wbyte;
  logic       scl_d, sda_d;
  logic       q_last, sample, op_end, tick, wr_nack;

  // Which bus operation the current state/step performs.
  always_comb begin
    op    = OP_NONE;
    wbyte = 8'h00;
    case (state)
      INIT_WR: begin
        case (step)
          2'd0:    op = OP_START;
          2'd1:    begin op = OP_WR; wbyte = ADDR_WR; end
          2'd2:    begin op = OP_WR; wbyte = 8'h6B;   end
          default: begin op = OP_WR; wbyte = 8'h00;   end
        endcase
      end
      RD_ADDR: begin
        if (step == 2'd0) op = OP_START;
        else begin op = OP_WR; wbyte = ADDR_WR; end
      end
      RD_PTR:   begin op = OP_WR; wbyte = 8'h3B; end
      RSTART:   op = OP_SR;
      RD_DEV:   begin op = OP_WR; wbyte = ADDR_RD; end
      RD_BYTES: op = OP_RD;
      STOP:     op = OP_STOP;
      default:  op = OP_NONE;
    endcase
  end

  // Pad levels per quarter (1 = pull low).
  always_comb begin
    scl_d = 1'b0;
    sda_d = 1'b0;
    case (op)
      OP_START: begin scl_d = (qtr == 2'd3); sda_d = (qtr != 2'd0); end
      OP_SR:    begin scl_d = (qtr == 2'd0) || (qtr == 2'd3); sda_d = (qtr >= 2'd2); end
      OP_STOP:  begin scl_d = (qtr == 2'd0); sda_d = (qtr <= 2'd1); end
      OP_WR: begin
        scl_d = (qtr == 2'd0) || (qtr == 2'd3);
        sda_d = (bitn < 4'd8) ? ~wbyte[3'(4'd7 - bitn)] : 1'b0;
      end
      OP_RD: begin
        scl_d = (qtr == 2'd0) || (qtr == 2'd3);
        // master ACKs bytes 0-4 and NACKs the last one
        sda_d = (bitn == 4'd8) && (byte_idx != 3'd5);
      end
      default: begin scl_d = 1'b0; sda_d = 1'b0; end
    endcase
  end

  assign q_last  = (qcnt == QW'(QTR - 1));
  assign sample  = (op == OP_WR || op == OP_RD) && (qtr == 2'd2) && q_last;
  assign op_end  = (op != OP_NONE) && q_last && (qtr == 2'd3) &&
                   ((op != OP_WR && op != OP_RD) || bitn == 4'd8);
  assign tick    = (tick_cnt == TW'(SAMPLE_DIV - 1));
  assign wr_nack = op_end && (op == OP_WR) && nack_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      step       <= 2'd0;
      qcnt       <= '0;
      qtr        <= 2'd0;
      bitn       <= 4'd0;
      byte_idx   <= 3'd0;
      shreg      <= 8'h00;
      rd_buf     <= 48'h0;
      nack_seen  <= 1'b0;
      nack_flag  <= 1'b0;
      from_init  <= 1'b0;
      init_req   <= 1'b1;
      tick_cnt   <= '0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
      data_valid <= 1'b0;
      ax         <= '0;
      ay         <= '0;
      az         <= '0;
      init_done  <= 1'b0;
      busy       <= 1'b0;
      ack_error  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      ack_error  <= 1'b0;
      overrun    <= tick && enable && busy;
      scl_oe     <= scl_d;
      sda_oe     <= sda_d;
      tick_cnt   <= tick ? '0 : tick_cnt + 1'b1;

      // Quarter/bit engine; counters wrap to zero exactly at op_end.
      if (op != OP_NONE) begin
        if (q_last) begin
          qcnt <= '0;
          qtr  <= qtr + 2'd1;
          if (qtr == 2'd3 && (op == OP_WR || op == OP_RD))
            bitn <= (bitn == 4'd8) ? 4'd0 : bitn + 4'd1;
        end else begin
          qcnt <= qcnt + 1'b1;
        end
        if (sample) begin
          if (bitn < 4'd8)       shreg     <= {shreg[6:0], sda_i};
          else if (op == OP_WR)  nack_seen <= sda_i;
        end
      end

      if (wr_nack) begin
        ack_error <= 1'b1;
        nack_flag <= 1'b1;
        state     <= STOP;
      end else begin
        case (state)
          IDLE: begin
            if (!init_done) begin
              // wake write: immediately after reset, else retried on a tick
              if (init_req || tick) begin
                state    <= INIT_WR;
                step     <= 2'd0;
                busy     <= 1'b1;
                init_req <= 1'b0;
              end
            end else if (tick && enable) begin
              state <= RD_ADDR;
              step  <= 2'd0;
              busy  <= 1'b1;
            end
          end
          INIT_WR: if (op_end) begin
            if (step == 2'd3) begin
              state     <= STOP;
              from_init <= 1'b1;
            end else begin
              step <= step + 2'd1;
            end
          end
          RD_ADDR: if (op_end) begin
            if (step == 2'd0) step <= 2'd1;
            else              state <= RD_PTR;
          end
          RD_PTR: if (op_end) state <= RSTART;
          RSTART: if (op_end) state <= RD_DEV;
          RD_DEV: if (op_end) begin
            state    <= RD_BYTES;
            byte_idx <= 3'd0;
          end
          RD_BYTES: if (op_end) begin
            rd_buf <= {rd_buf[39:0], shreg};
            if (byte_idx == 3'd5) state <= STOP;
            else                  byte_idx <= byte_idx + 3'd1;
          end
          STOP: if (op_end) begin
            busy      <= 1'b0;
            nack_flag <= 1'b0;
            from_init <= 1'b0;
            if (nack_flag) begin
              state <= IDLE;
            end else if (from_init) begin
              init_done <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= DONE;
            end
          end
          DONE: begin
            data_valid <= 1'b1;
            ax         <= $signed(rd_buf[47:32]);
            ay         <= $signed(rd_buf[31:16]);
            az         <= $signed(rd_buf[15:0]);
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpu6050_sampler.sv
// Bench for mpu6050_sampler: open-drain bus with a behavioural MPU6050 slave,
// expected bus bytes and expected samples queued by the stimulus and checked
// by the slave and by the output monitor.
module tb_mpu6050_sampler;

  // QTR = 3.2 MHz / (4 * 400 kHz) = 2, SAMPLE_DIV = 3.2 MHz / 6.4 kHz = 500.
  // A read takes 672 bus clocks, so every read sees exactly one busy tick.
  localparam int CLK_HZ   = 3_200_000;
  localparam int I2C_HZ   = 400_000;
  localparam int RATE_HZ  = 6_400;
  localparam int SCL_PER  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic sda_i;
  logic scl_oe, sda_oe, data_valid, init_done, busy, ack_error, overrun;
  logic signed [15:0] ax, ay, az;

  logic s_pull = 1'b0;
  logic scl_line, sda_line;
  assign scl_line = ~scl_oe;
  assign sda_line = ~(sda_oe | s_pull);
  assign sda_i    = sda_line;

  mpu6050_sampler #(
    .CLK_FREQ_HZ(CLK_HZ), .I2C_FREQ_HZ(I2C_HZ),
    .SAMPLE_RATE_HZ(RATE_HZ), .DEV_ADDR(7'h68)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sda_i(sda_i),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .data_valid(data_valid),
    .ax(ax), .ay(ay), .az(az), .init_done(init_done), .busy(busy),
    .ack_error(ack_error), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [47:0] exp_q[$];   // expected {ax,ay,az} per data_valid
  logic [7:0]  bus_q[$];   // expected master-written bytes on the bus
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] samp(input int a, input int b, input int c);
    return {16'(a), 16'(b), 16'(c)};
  endfunction

  // ---------------- slave model ----------------
  logic [7:0] s_tx[6];
  int   s_nack_req = 0;
  int   s_nack_done = 0;
  int   s_mode = 0;          // 0 idle, 1 receiving, 2 transmitting
  int   s_bitc = 0;
  int   s_tx_idx = 0;
  int   s_starts = 0;
  int   s_stops = 0;
  int   s_cyc = 0;
  int   s_last_rise = 0;
  logic [7:0] s_sh = 8'h00;
  logic s_ackph = 1'b0, s_first = 1'b0, s_nacked = 1'b0, s_rdreq = 1'b0;
  logic s_prev_scl = 1'b1, s_prev_sda = 1'b1;
  logic s_mack = 1'b0;

  always @(negedge clk) begin
    s_cyc++;
    if (rst) begin
      s_mode = 0; s_pull = 1'b0; s_bitc = 0; s_ackph = 1'b0;
      s_prev_scl = 1'b1; s_prev_sda = 1'b1;
    end else begin
      if (s_prev_scl && scl_line && s_prev_sda && !sda_line) begin
        s_starts++;
        s_mode = 1; s_bitc = 0; s_ackph = 1'b0; s_first = 1'b1; s_pull = 1'b0;
      end else if (s_prev_scl && scl_line && !s_prev_sda && sda_line) begin
        s_stops++;
        s_mode = 0; s_pull = 1'b0;
      end else if (!s_prev_scl && scl_line) begin
        if (s_mode == 1 && s_bitc < 8) begin
          s_sh = {s_sh[6:0], sda_line};
          s_bitc++;
        end else if (s_mode == 2) begin
          if (s_bitc >= 1 && s_bitc <= 7)
            check("scl_period", 48'(s_cyc - s_last_rise), 48'(SCL_PER));
          if (s_bitc < 8) s_bitc++;
          else if (!s_ackph) begin
            s_mack = sda_line;
            check("master_ack", {47'd0, sda_line}, {47'd0, (s_tx_idx == 5)});
            s_ackph = 1'b1;
          end
        end
        s_last_rise = s_cyc;
      end else if (s_prev_scl && !scl_line) begin
        if (s_mode == 1 && s_bitc == 8) begin
          if (!s_ackph) begin
            if (bus_q.size() == 0) begin
              n_cmp++; n_fail++;
              $display("FAIL bus_byte: got %0h expected none", s_sh);
            end else begin
              check("bus_byte", {40'd0, s_sh}, {40'd0, bus_q.pop_front()});
            end
            s_nacked = (s_nack_req > s_nack_done) && (s_sh == 8'hD1);
            if (s_nacked) s_nack_done++;
            s_pull  = ~s_nacked;
            s_rdreq = s_first && s_sh[0];
            s_first = 1'b0;
            s_ackph = 1'b1;
          end else begin
            s_ackph = 1'b0; s_bitc = 0; s_pull = 1'b0;
            if (s_nacked) s_mode = 0;
            else if (s_rdreq) begin
              s_mode = 2; s_tx_idx = 0; s_pull = ~s_tx[0][7];
            end
          end
        end else if (s_mode == 2) begin
          if (s_bitc < 8) s_pull = ~s_tx[s_tx_idx][7 - s_bitc];
          else if (!s_ackph) s_pull = 1'b0;
          else begin
            s_ackph = 1'b0; s_bitc = 0; s_tx_idx++;
            if (s_tx_idx < 6 && !s_mack) s_pull = ~s_tx[s_tx_idx][7];
            else begin s_pull = 1'b0; s_mode = 0; end
          end
        end
      end
      s_prev_scl = scl_line;
      s_prev_sda = sda_line;
    end
  end

  // ---------------- output monitor ----------------
  int dv_cnt = 0, ae_cnt = 0, ov_cnt = 0, busy_rises = 0;
  logic prev_busy = 1'b0, prev_dv = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        dv_cnt++;
        check("dv_width", {47'd0, prev_dv}, 48'd0);
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL sample: got %0h expected none", {ax, ay, az});
        end else begin
          check("sample", {ax, ay, az}, exp_q.pop_front());
        end
      end
      if (ack_error) ae_cnt++;
      if (overrun) ov_cnt++;
      if (busy && !prev_busy) busy_rises++;
    end
    prev_busy = busy;
    prev_dv   = data_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic load_tx(input logic [7:0] b0, b1, b2, b3, b4, b5);
    s_tx[0] = b0; s_tx[1] = b1; s_tx[2] = b2;
    s_tx[3] = b3; s_tx[4] = b4; s_tx[5] = b5;
  endtask

  task automatic push_bytes(input logic [7:0] b0, b1, b2);
    bus_q.push_back(b0); bus_q.push_back(b1); bus_q.push_back(b2);
  endtask

  // what: 0 init_done, 1 dv_cnt>=target, 2 ae_cnt>=target,
  //       3 slave sending byte index target, 4 busy
  task automatic wait_for(input int what, input int target, input int budget, input string name);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (what)
        0: hit = init_done;
        1: hit = (dv_cnt >= target);
        2: hit = (ae_cnt >= target);
        3: hit = (s_mode == 2) && (s_tx_idx == target);
        default: hit = busy;
      endcase
    end
    check(name, {47'd0, hit}, 48'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int st0, b0;
  initial begin
    rst = 1'b1;
    enable = 1'b1;
    load_tx(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_scl_oe", {47'd0, scl_oe}, 48'd0);
    check("rst_sda_oe", {47'd0, sda_oe}, 48'd0);
    check("rst_dv", {47'd0, data_valid}, 48'd0);
    check("rst_axyz", {ax, ay, az}, 48'd0);
    check("rst_init_done", {47'd0, init_done}, 48'd0);
    check("rst_busy", {47'd0, busy}, 48'd0);
    check("rst_ack_error", {47'd0, ack_error}, 48'd0);
    check("rst_overrun", {47'd0, overrun}, 48'd0);

    // 1: wake write START D0 6B 00 STOP
    push_bytes(8'hD0, 8'h6B, 8'h00);
    rst = 1'b0;
    wait_for(0, 0, 2000, "init_reached");
    check("init_bytes_left", 48'(bus_q.size()), 48'd0);
    check("init_starts", 48'(s_starts), 48'd1);
    check("init_stops", 48'(s_stops), 48'd1);
    check("init_no_dv", 48'(dv_cnt), 48'd0);

    // 2: 61A8=25000, FED4=-300, 0064=100
    load_tx(8'h61, 8'hA8, 8'hFE, 8'hD4, 8'h00, 8'h64);
    push_bytes(8'hD0, 8'h3B, 8'hD1);
    exp_q.push_back(samp(25000, -300, 100));
    wait_for(1, 1, 1500, "read1_done");
    check("read1_bytes_left", 48'(bus_q.size()), 48'd0);
    check("read1_stops", 48'(s_stops), 48'd2);

    // 3: slave NACKs 0xD1 once; outputs must hold
    s_nack_req = 1;
    push_bytes(8'hD0, 8'h3B, 8'hD1);
    wait_for(2, 1, 1500, "nack_seen");
    repeat (50) @(negedge clk);
    check("nack_stop", 48'(s_stops), 48'd3);
    check("nack_no_dv", 48'(dv_cnt), 48'd1);
    check("nack_hold", {ax, ay, az}, samp(25000, -300, 100));
    check("nack_idle", {47'd0, busy}, 48'd0);

    // next tick reads normally: 8000=-32768, 7FFF=32767, FFFF=-1
    load_tx(8'h80, 8'h00, 8'h7F, 8'hFF, 8'hFF, 8'hFF);
    push_bytes(8'hD0, 8'h3B, 8'hD1);
    exp_q.push_back(samp(-32768, 32767, -1));
    wait_for(1, 2, 1500, "read3_done");

    // 4: one overrun per completed read (ticks land mid-read)
    check("ack_error_cnt", 48'(ae_cnt), 48'd1);
    check("overrun_cnt", 48'(ov_cnt), 48'd2);
    check("dv_cnt", 48'(dv_cnt), 48'd2);

    // 5: reset during byte 3 of the read
    load_tx(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    push_bytes(8'hD0, 8'h3B, 8'hD1);
    wait_for(3, 3, 1500, "byte3_reached");
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_scl_oe", {47'd0, scl_oe}, 48'd0);
    check("mid_rst_sda_oe", {47'd0, sda_oe}, 48'd0);
    check("mid_rst_axyz", {ax, ay, az}, 48'd0);
    check("mid_rst_init_done", {47'd0, init_done}, 48'd0);
    check("mid_rst_busy", {47'd0, busy}, 48'd0);
    repeat (2) @(negedge clk);
    st0 = s_starts;
    push_bytes(8'hD0, 8'h6B, 8'h00);
    rst = 1'b0;
    wait_for(0, 0, 2000, "reinit_reached");
    check("reinit_starts", 48'(s_starts - st0), 48'd1);
    check("reinit_bytes_left", 48'(bus_q.size()), 48'd0);

    // 6: enable low for three tick periods, no transactions
    enable = 1'b0;
    st0 = s_starts;
    b0 = busy_rises;
    repeat (1500) @(negedge clk);
    check("disabled_starts", 48'(s_starts - st0), 48'd0);
    check("disabled_busy", 48'(busy_rises - b0), 48'd0);
    check("disabled_dv", 48'(dv_cnt), 48'd2);

    // 1234=4660, EDCC=-4660, 0000=0; enable dropped mid-read
    load_tx(8'h12, 8'h34, 8'hED, 8'hCC, 8'h00, 8'h00);
    push_bytes(8'hD0, 8'h3B, 8'hD1);
    exp_q.push_back(samp(4660, -4660, 0));
    enable = 1'b1;
    wait_for(4, 0, 600, "read_after_enable");
    enable = 1'b0;
    wait_for(1, 3, 1000, "read_completes_disabled");
    st0 = s_starts;
    repeat (1100) @(negedge clk);
    check("late_ticks_ignored", 48'(s_starts - st0), 48'd0);
    check("final_overrun_cnt", 48'(ov_cnt), 48'd2);
    check("final_ack_error_cnt", 48'(ae_cnt), 48'd1);
    check("exp_q_empty", 48'(exp_q.size()), 48'd0);
    check("bus_q_empty", 48'(bus_q.size()), 48'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mpu6050_sampler.md
Name: mpu6050_sampler

Overview:
I2C master that owns the accelerometer link and produces the sample stream consumed by fall_detect. After reset it wakes the MPU6050 once. It then performs a burst read of ACCEL_XOUT_H..ACCEL_ZOUT_L at a fixed sample rate and emits signed ax/ay/az with a one-cycle data_valid strobe. It sits between the open-drain I2C pads and fall_detect.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency
I2C_FREQ_HZ, 400_000, SCL frequency; QTR = CLK_FREQ_HZ/(4*I2C_FREQ_HZ) clocks per quarter-bit (min 1)
SAMPLE_RATE_HZ, 50, read-trigger rate; SAMPLE_DIV = CLK_FREQ_HZ/SAMPLE_RATE_HZ clocks per tick
DEV_ADDR, 7'h68, 7-bit slave address

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  gates sample ticks; the init write always runs
sda_i  in  1  SDA pad input
scl_oe  out  1  1 = pull SCL low, 0 = release
sda_oe  out  1  1 = pull SDA low, 0 = release
data_valid  out  1  one-cycle strobe; ax/ay/az are new
ax, ay, az  out  16 signed  acceleration, big-endian register pairs
init_done  out  1  high after a successful wake write, sticky
busy  out  1  high while any I2C transaction is in progress
ack_error  out  1  one-cycle pulse when a NACK is detected on an address or write byte
overrun  out  1  one-cycle pulse when an enabled tick arrives while busy

Behaviour:
- Single clock domain, one clock only. Reset is synchronous and active-high.
- Reset values: scl_oe=0, sda_oe=0 (bus released), data_valid=0, ax=ay=az=0, init_done=0, busy=0, ack_error=0, overrun=0.
- Tick counter is free-running modulo SAMPLE_DIV and is cleared by rst. A tick is taken only if enable=1, init_done=1 and the FSM is IDLE.
  - Tick while busy with enable=1: pulse overrun; the tick is dropped, not queued.
- Bit engine: each bit is 4 quarters of QTR clocks.
  - q0: SCL low, drive SDA.
  - q1: release SCL.
  - q2: SCL high; sample sda_i at the last clock of q2.
  - q3: pull SCL low.
- START: SDA falls while SCL is high. Repeated START (Sr): SDA released, SCL released, then SDA falls. STOP: SDA low, SCL released, then SDA released.
- No clock stretching support; sda_i is the only bus input.
- Top FSM states: INIT_WR, IDLE, RD_ADDR, RD_PTR, RSTART, RD_DEV, RD_BYTES, STOP, DONE.
  - INIT_WR (entered 1 cycle after rst deasserts): START, 0xD0, 0x6B, 0x00, STOP. On success set init_done and go to IDLE.
  - IDLE -> on tick: START, 0xD0, 0x3B, Sr, 0xD1.
  - RD_BYTES: read 6 bytes MSB-first. Master ACKs bytes 0-4 (sda_oe=1 during the ACK bit) and NACKs byte 5 (sda_oe=0). Then STOP, then DONE.
- ACK bit after each address or write byte: sda_i=1 means NACK.
  - On NACK: pulse ack_error, issue STOP, return to IDLE (or retry INIT_WR at the next tick if init_done=0).
  - No data_valid and no output update on a NACK.
- Data assembly: ax={b0,b1}, ay={b2,b3}, az={b4,b5}, two's complement, no scaling.
  - Outputs update in the DONE cycle together with data_valid=1 for exactly one clock, then hold until the next successful read.
  - DONE occurs 1 clock after the STOP quarter sequence ends.
- busy=1 from the START of any transaction through the last STOP quarter; it deasserts in the DONE cycle.
- rst asserted mid-transaction: next clock returns every output to its reset value and releases the bus. There is no STOP on reset; the slave relies on the next START.
- enable deasserted mid-read: the current transaction completes and emits data_valid; later ticks are ignored.

Test Plan:
1. Reset release with an ACKing slave model: bus sees START, 0xD0/ACK, 0x6B/ACK, 0x00/ACK, STOP -> init_done=1; no data_valid before the first tick.
2. Slave returns 61 A8 FE D4 00 64 -> one data_valid pulse with ax=25000, ay=-300, az=100; master ACKs 5 bytes, NACKs the last, issues STOP; SCL period is 4*QTR clocks.
3. Slave NACKs 0xD1 -> ack_error pulses once, STOP follows, no data_valid, ax/ay/az keep their previous values; the next tick reads normally.
4. SAMPLE_DIV set smaller than the transaction length -> overrun pulses once per tick that lands while busy=1; the data_valid count equals the completed reads.
5. rst asserted during RD_BYTES byte 3 -> scl_oe=sda_oe=0, ax=ay=az=0, init_done=0 the next clock; the init write repeats after release.
6. enable=0 -> no transactions after init for 3 tick periods; enable=1 -> a read starts on the first subsequent tick.
